// File: rtl/axi_dmac_pkg.sv
// Shared DMAC types: scheduler states, parameter bundle
// and the burst sizing helper.
package axi_dmac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } sched_state_t;

    typedef struct packed {
        int unsigned addr_width;
        int unsigned length_width;
        int unsigned max_bytes_per_burst;
        int unsigned dma_length_align;
        int unsigned max_outstanding;
    } dmac_params_t;

    // Bytes until the next max_bytes boundary, clipped to what is left.
    function automatic logic [31:0] burst_bytes(
        input logic [31:0] addr,
        input logic [31:0] remaining,
        input logic [31:0] max_bytes
    );
        logic [31:0] w_room;
        w_room = max_bytes - (addr & (max_bytes - 32'd1));
        return (remaining < w_room) ? remaining : w_room;
    endfunction

endpackage

// File: rtl/dmac_outstanding_counter.sv
// Issued-but-not-completed burst counter with
// saturation at zero and an underflow strobe.
module dmac_outstanding_counter #(
    parameter int MAX = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic       underflow
);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= 4'd0;
        end else if (inc && !dec) begin
            r_count <= r_count + 4'd1;
        end else if (dec && !inc && !empty) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign count     = r_count;
    assign empty     = (r_count == 4'd0);
    assign full      = (r_count >= 4'(MAX));
    assign underflow = dec && empty;

endmodule

// File: rtl/dmac_burst_scheduler.sv
// Splits one byte-addressed transfer into boundary-safe
// bursts and tracks their completion.
module dmac_burst_scheduler
    import axi_dmac_pkg::*;
#(
    parameter int ADDR_WIDTH          = 32,
    parameter int LENGTH_WIDTH        = 24,
    parameter int MAX_BYTES_PER_BURST = 128,
    parameter int DMA_LENGTH_ALIGN    = 3,
    parameter int MAX_OUTSTANDING     = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    xfer_valid,
    output logic                    xfer_ready,
    input  logic [ADDR_WIDTH-1:0]   xfer_addr,
    input  logic [LENGTH_WIDTH-1:0] xfer_length,
    input  logic                    abort,
    output logic                    burst_valid,
    input  logic                    burst_ready,
    output logic [ADDR_WIDTH-1:0]   burst_addr,
    output logic [$clog2(MAX_BYTES_PER_BURST)-1:0] burst_length,
    output logic                    burst_last,
    input  logic                    burst_done,
    output logic                    xfer_done,
    output logic                    xfer_aborted,
    output logic                    busy,
    output logic [3:0]              outstanding,
    output logic                    error
);

    localparam int BLW = $clog2(MAX_BYTES_PER_BURST);
    localparam int RW  = LENGTH_WIDTH + 1;
    localparam logic [LENGTH_WIDTH-1:0] ALIGN_MASK =
        LENGTH_WIDTH'((1 << DMA_LENGTH_ALIGN) - 1);
    localparam logic [31:0] MAXB = 32'(MAX_BYTES_PER_BURST);
    localparam logic [RW-1:0] ONE_R = RW'(1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic                  r_xfer_ready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [RW-1:0]         r_remaining;
    logic                  r_burst_valid;
    logic [ADDR_WIDTH-1:0] r_burst_addr;
    logic [BLW-1:0]        r_burst_len;
    logic                  r_burst_last;
    logic                  r_aborted;
    logic                  r_done;
    logic                  r_xfer_aborted;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_hs;
    logic                  w_load;
    logic                  w_finish;
    logic [31:0]           w_bytes;
    logic [3:0]            w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_underflow;

    assign w_accept = r_xfer_ready && xfer_valid;
    assign w_hs     = r_burst_valid && burst_ready;
    assign w_bytes  = burst_bytes(32'(r_addr), 32'(r_remaining), MAXB);

    dmac_outstanding_counter #(
        .MAX(MAX_OUTSTANDING)
    ) u_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (w_hs),
        .dec      (burst_done),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty),
        .underflow(w_underflow)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                // A presented burst always finishes its handshake first.
                if (w_hs) begin
                    if (r_burst_last || r_aborted || abort)
                        w_state_nxt = DRAIN;
                end else if (!r_burst_valid) begin
                    if (abort || r_aborted)
                        w_state_nxt = DRAIN;
                    else if (!w_full)
                        w_load = 1'b1;
                end
            end
            DRAIN: begin
                if (w_empty) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_xfer_ready   <= 1'b0;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_burst_valid  <= 1'b0;
            r_burst_addr   <= '0;
            r_burst_len    <= '0;
            r_burst_last   <= 1'b0;
            r_aborted      <= 1'b0;
            r_done         <= 1'b0;
            r_xfer_aborted <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_xfer_ready   <= (w_state_nxt == IDLE);
            r_done         <= w_finish;
            r_xfer_aborted <= w_finish && r_aborted;
            r_error        <= r_error || w_underflow;
            if (w_accept) begin
                r_addr      <= xfer_addr;
                r_remaining <= {1'b0, xfer_length | ALIGN_MASK} + ONE_R;
                r_aborted   <= 1'b0;
            end else if (r_state == ISSUE && abort) begin
                r_aborted <= 1'b1;
            end
            // Cursor advances at load; the payload registers hold the burst.
            if (w_load) begin
                r_burst_valid <= 1'b1;
                r_burst_addr  <= r_addr;
                r_burst_len   <= BLW'(w_bytes - 32'd1);
                r_burst_last  <= (w_bytes == 32'(r_remaining));
                r_addr        <= r_addr + ADDR_WIDTH'(w_bytes);
                r_remaining   <= r_remaining - RW'(w_bytes);
            end else if (w_hs) begin
                r_burst_valid <= 1'b0;
            end
        end
    end

    assign xfer_ready   = r_xfer_ready;
    assign burst_valid  = r_burst_valid;
    assign burst_addr   = r_burst_addr;
    assign burst_length = r_burst_len;
    assign burst_last   = r_burst_last;
    assign xfer_done    = r_done;
    assign xfer_aborted = r_xfer_aborted;
    assign busy         = (r_state != IDLE);
    assign outstanding  = w_count;
    assign error        = r_error;

endmodule
